// File: rtl/filtro_biquad_cascada.sv
// Cascade of direct-form-II biquad sections sharing one multiplier and one accumulator.
// Five products per section; a1/a2 are stored pre-negated so every feedback term is added.
module filtro_biquad_cascada #(
    parameter int largo = 24,
    parameter int mag   = 8,
    parameter int pres  = 16,
    parameter int secc  = 2,
    parameter int aw    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [largo:0]   data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [largo:0]   data_out,
    output logic             valid_o,
    output logic             sat_o,
    output logic             drop_o,
    input  logic             coef_we,
    input  logic [aw-1:0]    coef_addr,
    input  logic [largo:0]   coef_data
);
    localparam int W  = largo + 1;
    localparam int NC = 5 * secc;
    localparam int SW = (secc > 1) ? $clog2(secc) : 1;

    localparam logic signed [W-1:0]   MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [2*W-1:0] MAX2 = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MIN2 = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [W-1:0]          ONE  = {{(W-1){1'b0}}, 1'b1} << pres;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_reg;
    logic [2:0]           step_reg;
    logic [SW-1:0]        sec_reg;
    logic signed [W-1:0]  x_reg;
    logic signed [W-1:0]  acc_reg;
    logic signed [W-1:0]  w_reg;
    logic                 flag_reg;

    logic signed [W-1:0]  coef_arr [NC];
    logic signed [W-1:0]  w1_arr [secc];
    logic signed [W-1:0]  w2_arr [secc];

    logic                 last_step;
    logic                 coef_wr_ok;

    assign last_step  = (state_reg == CALC) && (step_reg == 3'd4);
    assign coef_wr_ok = (state_reg == IDLE) && coef_we;

    // Coefficient file; reset value is passthrough (b0 = 1.0 in every section).
    generate
        for (genvar gi = 0; gi < NC; gi++) begin : g_coef
            logic signed [W-1:0] coef_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    coef_q <= ((gi % 5) == 0) ? ONE : '0;
                end else if (coef_wr_ok && (coef_addr == aw'(gi))) begin
                    coef_q <= coef_data;
                end
            end
            assign coef_arr[gi] = coef_q;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < secc; gi++) begin : g_state
            logic signed [W-1:0] w1_q;
            logic signed [W-1:0] w2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    w1_q <= '0;
                    w2_q <= '0;
                end else if (last_step && (sec_reg == SW'(gi))) begin
                    w2_q <= w1_q;
                    w1_q <= w_reg;
                end
            end
            assign w1_arr[gi] = w1_q;
            assign w2_arr[gi] = w2_q;
        end
    endgenerate

    // Operand selection: the step decides which coefficient and which state word meet the multiplier.
    logic [2:0]           coef_k;
    logic [aw-1:0]        coef_idx;
    logic signed [W-1:0]  coef_sel;
    logic signed [W-1:0]  oper;
    logic signed [W-1:0]  addend;

    always_comb begin
        coef_k = 3'd0;
        oper   = w1_arr[sec_reg];
        case (step_reg)
            3'd0: begin coef_k = 3'd3; oper = w1_arr[sec_reg]; end
            3'd1: begin coef_k = 3'd4; oper = w2_arr[sec_reg]; end
            3'd2: begin coef_k = 3'd0; oper = w_reg;           end
            3'd3: begin coef_k = 3'd1; oper = w1_arr[sec_reg]; end
            3'd4: begin coef_k = 3'd2; oper = w2_arr[sec_reg]; end
            default: begin coef_k = 3'd0; oper = w_reg;        end
        endcase
        coef_idx = aw'(sec_reg) * aw'(5) + aw'(coef_k);
        coef_sel = coef_arr[coef_idx];
        addend   = (step_reg == 3'd0) ? x_reg : acc_reg;
    end

    logic signed [2*W-1:0] prod_full;
    logic signed [2*W-1:0] prod_sh;
    logic signed [W-1:0]   prod_sat;
    logic                  prod_ovf;
    logic signed [W:0]     sum_full;
    logic signed [W-1:0]   sum_sat;
    logic                  sum_ovf;
    logic signed [W-1:0]   acc_next;
    logic                  sat_now;

    always_comb begin
        prod_full = coef_sel * oper;
        prod_sh   = prod_full >>> pres;
        prod_ovf  = (prod_sh > MAX2) || (prod_sh < MIN2);
        if (prod_sh > MAX2)      prod_sat = MAXV;
        else if (prod_sh < MIN2) prod_sat = MINV;
        else                     prod_sat = prod_sh[W-1:0];

        sum_full = {addend[W-1], addend} + {prod_sat[W-1], prod_sat};
        sum_ovf  = (sum_full[W] != sum_full[W-1]);
        if (sum_ovf) sum_sat = sum_full[W] ? MINV : MAXV;
        else         sum_sat = sum_full[W-1:0];

        // Step 2 starts the feedforward sum fresh, so only the product can saturate there.
        acc_next = (step_reg == 3'd2) ? prod_sat : sum_sat;
        sat_now  = prod_ovf || ((step_reg != 3'd2) && sum_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            sec_reg   <= '0;
            x_reg     <= '0;
            acc_reg   <= '0;
            w_reg     <= '0;
            flag_reg  <= 1'b0;
            ready_o   <= 1'b1;
            data_out  <= '0;
            valid_o   <= 1'b0;
            sat_o     <= 1'b0;
            drop_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            drop_o  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_o <= 1'b1;
                    if (valid_i) begin
                        x_reg     <= data_i;
                        sec_reg   <= '0;
                        step_reg  <= 3'd0;
                        flag_reg  <= 1'b0;
                        ready_o   <= 1'b0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    drop_o   <= valid_i;
                    acc_reg  <= acc_next;
                    flag_reg <= flag_reg | sat_now;
                    if (step_reg == 3'd1) w_reg <= acc_next;
                    if (step_reg == 3'd4) begin
                        x_reg    <= acc_next;
                        step_reg <= 3'd0;
                        if (sec_reg == SW'(secc - 1)) state_reg <= DONE;
                        else                          sec_reg   <= SW'(sec_reg + 1'b1);
                    end else begin
                        step_reg <= step_reg + 3'd1;
                    end
                end
                DONE: begin
                    drop_o    <= valid_i;
                    data_out  <= acc_reg;
                    valid_o   <= 1'b1;
                    sat_o     <= flag_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filtro_biquad_cascada.sv
// Directed bench for the two-section biquad cascade: latency, recursion, saturation,
// dropped samples, coefficient write gating and mid-computation reset.
module tb_filtro_biquad_cascada;
    localparam int W = 25;
    localparam logic [W-1:0] ONE = 25'h0010000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_out;
    logic         valid_o;
    logic         sat_o;
    logic         drop_o;
    logic         coef_we;
    logic [3:0]   coef_addr;
    logic [W-1:0] coef_data;

    int checks = 0;
    int errors = 0;

    filtro_biquad_cascada #(.largo(24), .mag(8), .pres(16), .secc(2), .aw(4)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_out(data_out), .valid_o(valid_o), .sat_o(sat_o), .drop_o(drop_o),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst = 1'b1; valid_i = 1'b0; coef_we = 1'b0;
        data_i = '0; coef_addr = '0; coef_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [W-1:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Waits for ready_o, sends one sample, then waits (bounded) for the result.
    task automatic send(input logic [W-1:0] d, output logic [W-1:0] r, output logic s, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        data_i = d; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        lat = -1; r = 'x; s = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = k; r = data_out; s = sat_o;
                break;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks += 5;
        if (data_out !== '0)  begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o got %b want 0", valid_o); end
        if (sat_o !== 1'b0)   begin errors++; $display("FAIL reset_sat_o got %b want 0", sat_o); end
        if (drop_o !== 1'b0)  begin errors++; $display("FAIL reset_drop_o got %b want 0", drop_o); end
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_o got %b want 1", ready_o); end
        $display("test_reset: outputs at reset values checked");
    endtask

    task automatic test_passthrough;
        logic [W-1:0] r;
        logic s;
        int nvalid;
        r = '0; s = 1'b0; nvalid = 0;
        do_reset();
        @(negedge clk);
        data_i = ONE; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks += 2;
            if (ready_o !== (k >= 12)) begin
                errors++; $display("FAIL pass_ready k=%0d got %b want %b", k, ready_o, (k >= 12));
            end
            if (valid_o !== (k == 11)) begin
                errors++; $display("FAIL pass_valid k=%0d got %b want %b", k, valid_o, (k == 11));
            end
            if (valid_o) begin r = data_out; s = sat_o; nvalid++; end
        end
        checks += 3;
        if (nvalid != 1) begin errors++; $display("FAIL pass_count got %0d want 1", nvalid); end
        if (r !== ONE)   begin errors++; $display("FAIL pass_data got %h want %h", r, ONE); end
        if (s !== 1'b0)  begin errors++; $display("FAIL pass_sat got %b want 0", s); end
        $display("test_passthrough: in=%h out=%h sat=%b", ONE, r, s);
    endtask

    task automatic test_impulse;
        logic [W-1:0] exp_y [4];
        logic [W-1:0] r;
        logic s;
        int lat;
        exp_y[0] = 25'h0010000; exp_y[1] = 25'h0008000;
        exp_y[2] = 25'h0004000; exp_y[3] = 25'h0002000;
        do_reset();
        write_coef(4'd3, 25'h0008000);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? ONE : '0, r, s, lat);
            checks += 3;
            if (lat != 11)       begin errors++; $display("FAIL impulse_lat[%0d] got %0d want 11", i, lat); end
            if (r !== exp_y[i])  begin errors++; $display("FAIL impulse_y[%0d] got %h want %h", i, r, exp_y[i]); end
            if (s !== 1'b0)      begin errors++; $display("FAIL impulse_sat[%0d] got %b want 0", i, s); end
            $display("test_impulse: n=%0d out=%h", i, r);
        end
    endtask

    task automatic test_saturation;
        logic [W-1:0] in_v [3];
        logic [W-1:0] exp_y [3];
        logic         exp_s [3];
        logic [W-1:0] r;
        logic s;
        int lat;
        in_v[0] = 25'h0C80000; exp_y[0] = 25'h0FFFFFF; exp_s[0] = 1'b1;
        in_v[1] = 25'h1380000; exp_y[1] = 25'h1000000; exp_s[1] = 1'b1;
        in_v[2] = 25'h0010000; exp_y[2] = 25'h0020000; exp_s[2] = 1'b0;
        do_reset();
        write_coef(4'd0, 25'h0020000);
        for (int i = 0; i < 3; i++) begin
            send(in_v[i], r, s, lat);
            checks += 2;
            if (r !== exp_y[i]) begin errors++; $display("FAIL sat_y[%0d] got %h want %h", i, r, exp_y[i]); end
            if (s !== exp_s[i]) begin errors++; $display("FAIL sat_flag[%0d] got %b want %b", i, s, exp_s[i]); end
            $display("test_saturation: in=%h out=%h sat=%b", in_v[i], r, s);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] r;
        int nvalid, ndrop;
        r = '0; nvalid = 0; ndrop = 0;
        do_reset();
        @(negedge clk);
        data_i = 25'h0030000; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (drop_o !== (k == 3)) begin
                errors++; $display("FAIL drop_pulse k=%0d got %b want %b", k, drop_o, (k == 3));
            end
            if (valid_o) begin nvalid++; r = data_out; end
            if (drop_o) ndrop++;
            if (k == 2) begin data_i = 25'h0070000; valid_i = 1'b1; end
            if (k == 3) valid_i = 1'b0;
        end
        checks += 3;
        if (nvalid != 1)        begin errors++; $display("FAIL drop_valid_count got %0d want 1", nvalid); end
        if (ndrop != 1)         begin errors++; $display("FAIL drop_count got %0d want 1", ndrop); end
        if (r !== 25'h0030000)  begin errors++; $display("FAIL drop_result got %h want 0030000", r); end
        $display("test_back_to_back: valid=%0d drop=%0d out=%h", nvalid, ndrop, r);
    endtask

    task automatic test_coef_gating;
        logic [W-1:0] r;
        logic s;
        int lat;
        r = '0;
        do_reset();
        @(negedge clk);
        data_i = 25'h0018000; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (valid_o) r = data_out;
            if (k == 2) begin coef_we = 1'b1; coef_addr = 4'd0; coef_data = 25'h0020000; end
            if (k == 3) coef_we = 1'b0;
        end
        checks++;
        if (r !== 25'h0018000) begin errors++; $display("FAIL busy_write_result got %h want 0018000", r); end
        $display("test_coef_gating: busy write, out=%h", r);

        send(25'h0018000, r, s, lat);
        checks++;
        if (r !== 25'h0018000) begin errors++; $display("FAIL busy_write_after got %h want 0018000", r); end
        $display("test_coef_gating: after busy write, out=%h", r);

        write_coef(4'd0, 25'h0020000);
        send(25'h0018000, r, s, lat);
        checks++;
        if (r !== 25'h0030000) begin errors++; $display("FAIL idle_write_result got %h want 0030000", r); end
        $display("test_coef_gating: idle write, out=%h", r);

        // Write and sample in the same idle cycle: the sample must see b0 = 0.5.
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 25'h0008000;
        data_i = 25'h0020000; valid_i = 1'b1;
        @(negedge clk);
        coef_we = 1'b0; valid_i = 1'b0;
        lat = -1; r = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (valid_o) begin lat = k; r = data_out; break; end
        end
        checks += 2;
        if (lat != 11)         begin errors++; $display("FAIL same_cycle_lat got %0d want 11", lat); end
        if (r !== 25'h0010000) begin errors++; $display("FAIL same_cycle_result got %h want 0010000", r); end
        $display("test_coef_gating: same-cycle write, out=%h", r);
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] r;
        logic s;
        int lat, nvalid;
        nvalid = 0;
        do_reset();
        write_coef(4'd0, 25'h0020000);
        @(negedge clk);
        data_i = ONE; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 2;
        if (ready_o !== 1'b1)  begin errors++; $display("FAIL midrst_ready got %b want 1", ready_o); end
        if (data_out !== '0)   begin errors++; $display("FAIL midrst_data_out got %h want 0", data_out); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid_o) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin errors++; $display("FAIL midrst_valid_count got %0d want 0", nvalid); end
        send(ONE, r, s, lat);
        checks += 3;
        if (lat != 11)  begin errors++; $display("FAIL midrst_lat got %0d want 11", lat); end
        if (r !== ONE)  begin errors++; $display("FAIL midrst_result got %h want %h", r, ONE); end
        if (s !== 1'b0) begin errors++; $display("FAIL midrst_sat got %b want 0", s); end
        $display("test_reset_mid: abandoned=%0d out=%h", nvalid, r);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_impulse();
        test_saturation();
        test_back_to_back();
        test_coef_gating();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
